// File: rtl/cbd_sampler.sv
// Centered-binomial noise sampler for eta=2/3: gearboxes a PRF word stream into
// LANES coefficients per beat, each already reduced into [0, Q-1].
module cbd_sampler #(
  parameter int unsigned IN_W   = 64,
  parameter int unsigned LANES  = 4,
  parameter int unsigned N_COEF = 256,
  parameter int unsigned Q      = 3329,
  parameter int unsigned COEF_W = 12,
  localparam int unsigned IDX_W = $clog2(N_COEF / LANES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    eta_sel,
  input  logic [IN_W-1:0]         in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [LANES*COEF_W-1:0] out_coefs,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned N_BEATS = N_COEF / LANES;
  localparam int unsigned BUF_W   = 2 * IN_W;
  localparam int unsigned CNT_W   = $clog2(BUF_W + 1);
  localparam int unsigned NEED2   = 4 * LANES;
  localparam int unsigned NEED3   = 6 * LANES;
  localparam int unsigned BITS2   = N_COEF * 4;
  localparam int unsigned BITS3   = N_COEF * 6;
  localparam int unsigned BITS_W  = $clog2(BITS3 + IN_W + 1);
  localparam int unsigned LD_W    = $clog2(N_BEATS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic                      eta3_q, eta3_d;
  logic [BUF_W-1:0]          buf_q, buf_d, buf_sh;
  logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_sh, need;
  logic [BITS_W-1:0]         bits_q, bits_d, total_d;
  logic [LD_W-1:0]           ld_q, ld_d;
  logic [LANES*COEF_W-1:0]   coefs_d, beat_coefs;
  logic                      valid_d, in_ready_d, busy_d, done_d;
  logic [IDX_W-1:0]          idx_d;
  logic                      in_fire, out_fire, load;

  // One lane: popcount(lo) - popcount(hi), wrapped into [0, Q-1].
  function automatic logic [COEF_W-1:0] cbd_coef(input logic [2:0] lo, input logic [2:0] hi);
    logic [1:0] a, b;
    a = 2'(lo[0]) + 2'(lo[1]) + 2'(lo[2]);
    b = 2'(hi[0]) + 2'(hi[1]) + 2'(hi[2]);
    if (a >= b) return COEF_W'(a - b);
    else        return COEF_W'(Q) - COEF_W'(b - a);
  endfunction

  // Coefficients for the beat sitting at the bottom of the buffer.
  always_comb begin
    beat_coefs = '0;
    for (int j = 0; j < LANES; j++) begin
      if (eta3_q)
        beat_coefs[COEF_W*j +: COEF_W] = cbd_coef(buf_q[6*j +: 3], buf_q[6*j+3 +: 3]);
      else
        beat_coefs[COEF_W*j +: COEF_W] = cbd_coef({1'b0, buf_q[4*j +: 2]},
                                                  {1'b0, buf_q[4*j+2 +: 2]});
    end
  end

  // Next-state, gearbox and output-register logic.
  always_comb begin
    state_d = state_q;
    eta3_d  = eta3_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    ld_d    = ld_q;
    coefs_d = out_coefs;
    valid_d = out_valid;
    idx_d   = out_idx;

    need     = eta3_q ? CNT_W'(NEED3) : CNT_W'(NEED2);
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    load     = (state_q == S_RUN) && (cnt_q >= need) && (ld_q < LD_W'(N_BEATS))
               && (!out_valid || out_ready);
    buf_sh   = load ? (buf_q >> need) : buf_q;
    cnt_sh   = load ? (cnt_q - need) : cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          eta3_d  = eta_sel;
          buf_d   = '0;
          cnt_d   = '0;
          bits_d  = '0;
          ld_d    = '0;
          valid_d = 1'b0;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        buf_d = buf_sh;
        cnt_d = cnt_sh;
        if (out_fire) begin
          idx_d   = out_idx + IDX_W'(1);
          valid_d = 1'b0;
        end
        if (load) begin
          coefs_d = beat_coefs;
          valid_d = 1'b1;
          ld_d    = ld_q + LD_W'(1);
        end
        // Bits above the valid count are always zero, so OR-in is an append.
        if (in_fire) begin
          buf_d  = buf_sh | (BUF_W'(in_data) << cnt_sh);
          cnt_d  = cnt_sh + CNT_W'(IN_W);
          bits_d = bits_q + BITS_W'(IN_W);
        end
        if (out_fire && (out_idx == IDX_W'(N_BEATS - 1))) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    total_d    = eta3_d ? BITS_W'(BITS3) : BITS_W'(BITS2);
    busy_d     = (state_d == S_RUN);
    done_d     = (state_d == S_DONE);
    in_ready_d = busy_d && (cnt_d <= CNT_W'(BUF_W - IN_W)) && (bits_d < total_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      eta3_q    <= 1'b0;
      buf_q     <= '0;
      cnt_q     <= '0;
      bits_q    <= '0;
      ld_q      <= '0;
      out_coefs <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      eta3_q    <= eta3_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      bits_q    <= bits_d;
      ld_q      <= ld_d;
      out_coefs <= coefs_d;
      out_valid <= valid_d;
      out_idx   <= idx_d;
      in_ready  <= in_ready_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: doc/cbd_sampler.md
# cbd_sampler

Parametrised centered-binomial-distribution sampler for the Kyber noise path; successor to the fixed eta=2 sampler. It consumes a stream of uniform PRF words and emits noise coefficients already reduced into [0, Q-1]. It supports eta=2 and eta=3, selected at run time per polynomial, using an internal bit gearbox. Input and output use valid/ready handshakes with full back-pressure. It sits between the SHAKE/PRF output buffer and the NTT input memory.

## Interface
- IN_W, 64, input word width; must be a multiple of 8 and at least 6*LANES.
- LANES, 4, coefficients per output beat.
- N_COEF, 256, coefficients per polynomial; must be a multiple of LANES.
- Q, 3329, modulus.
- COEF_W, 12, coefficient width; 2^COEF_W must exceed Q.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse that begins a polynomial; ignored while busy.
- eta_sel  in  1  0 selects eta=2, 1 selects eta=3; latched on an accepted start.
- in_data  in  IN_W  PRF bits; LSB is the oldest bit.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  sampler accepts in_data this cycle.
- out_coefs  out  LANES*COEF_W  lane j is at [COEF_W*j +: COEF_W].
- out_valid  out  1  out_coefs is valid.
- out_ready  in  1  downstream accepts out_coefs.
- out_idx  out  log2(N_COEF/LANES)  beat index within the polynomial.
- busy  out  1  a polynomial is in progress.
- done  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- States:
  - IDLE: on start, latch eta, clear the buffer, coefficient counter and out_idx, and go to RUN.
  - RUN: after the final beat handshake (beat N_COEF/LANES-1), go to DONE.
  - DONE: assert done for one cycle and go to IDLE.
- Bit buffer: BUF_W = 2*IN_W bits plus a count of valid bits. Bits are LSB-aligned, oldest first.
  - An input handshake appends in_data directly above the remaining valid bits.
- Beat need: NEED = 2*eta*LANES bits (16 for eta=2, 24 for eta=3).
- Coefficient j of a beat uses buffer bits [2*eta*j +: 2*eta]:
  - a = popcount of the low eta bits; b = popcount of the high eta bits.
  - coef = a-b when a≥b, otherwise Q+a-b.
  - Results: eta=2 gives {0,1,2,3327,3328}; eta=3 gives {0..3, 3326..3328}.
- Loading the output register: load when in RUN, count≥NEED, and the register is empty or being consumed this cycle.
  - On load, shift out NEED bits and increment out_idx after each accepted beat.
- in_ready = busy && count ≤ BUF_W-IN_W && fewer than N_COEF*2*eta bits have been requested so far.
  - No surplus words are accepted: exactly 16 words for eta=2, 24 for eta=3 at IN_W=64.
- Simultaneous input append and beat extraction in one cycle are both performed; the result is count+IN_W-NEED.
- Residual buffered bits at polynomial end are discarded.
- start while busy, or in DONE, is ignored; eta_sel changes mid-polynomial have no effect.

## Timing
- Reset values: in_ready=0, out_valid=0, out_coefs=0, out_idx=0, busy=0, done=0, state IDLE, count=0.
- busy rises the cycle after the start edge, and in_ready may assert in that same cycle.
- First latency: input handshake at edge t puts out_valid=1 after edge t+1.
- Sustained throughput: one beat per cycle while bits are available.
  - eta=2: 4 beats per input word. eta=3: 8 beats per 3 words.
- out_coefs, out_idx and out_valid are registered and stay stable while out_valid && !out_ready.
- done pulses the cycle after the final output handshake; busy falls in the same cycle done rises.
- Reset asserted mid-operation returns all outputs to their reset values immediately. Buffered data is lost; a new start is required.

## Test plan
- eta=2, 16 words of 0x3333333333333333, out_ready=1 -> 64 beats, every lane=2, out_idx 0..63, one done pulse, exactly 16 input handshakes.
- eta=2, words of 0xCCCCCCCCCCCCCCCC -> every lane=3327; mixed nibble 0x1 -> lane 1, nibble 0x4 -> lane 3328, nibble 0xF -> lane 0.
- eta=3, 24 words with repeating 6-bit group 0b000111 (the 24-bit pattern 0x1C71C7 tiled across word boundaries) -> every lane=3; groups 0b111000 -> 3326; check beats straddling words (beat 2 uses bits 48..71) against a model.
- Back-pressure: eta=3 with out_ready low for 20 cycles mid-run -> out_coefs held stable, in_ready drops once count>BUF_W-IN_W, no bit lost or duplicated versus the golden model.
- start pulsed during RUN with eta_sel toggled -> ignored, output unchanged; after done, a new start with eta=2 runs normally from out_idx=0.
- reset asserted at beat 30 -> all outputs 0 immediately; the following start produces the correct polynomial with no stale buffer bits.
